// File: rtl/alu_exec_unit.sv
// alu_exec_unit: two-stage integer execution unit on the result bus.
// S1 computes value / jump / next PC from the dispatched operands and
// S2 registers them onto the result_* outputs.
// Optional macro ALU_MUL_EN adds MUL/MULH/MULHSU/MULHU using partial
// products registered in S1 and summed in S2.
module alu_exec_unit #(
    parameter int ROB_POS_W = 5,
    parameter int OPENUM_W  = 6,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 alu_enable,
    input  logic [OPENUM_W-1:0]  alu_openum,
    input  logic [ROB_POS_W-1:0] alu_rob_pos,
    input  logic [XLEN-1:0]      alu_rs1_val,
    input  logic [XLEN-1:0]      alu_rs2_val,
    input  logic [XLEN-1:0]      alu_imm,
    input  logic [XLEN-1:0]      alu_pc,
    output logic                 result_ready,
    output logic [ROB_POS_W-1:0] result_rob_pos,
    output logic [XLEN-1:0]      result_val,
    output logic                 result_jump,
    output logic [XLEN-1:0]      result_pc
);

    localparam logic [OPENUM_W-1:0] OP_LUI    = OPENUM_W'(1);
    localparam logic [OPENUM_W-1:0] OP_AUIPC  = OPENUM_W'(2);
    localparam logic [OPENUM_W-1:0] OP_JAL    = OPENUM_W'(3);
    localparam logic [OPENUM_W-1:0] OP_JALR   = OPENUM_W'(4);
    localparam logic [OPENUM_W-1:0] OP_BEQ    = OPENUM_W'(5);
    localparam logic [OPENUM_W-1:0] OP_BNE    = OPENUM_W'(6);
    localparam logic [OPENUM_W-1:0] OP_BLT    = OPENUM_W'(7);
    localparam logic [OPENUM_W-1:0] OP_BGE    = OPENUM_W'(8);
    localparam logic [OPENUM_W-1:0] OP_BLTU   = OPENUM_W'(9);
    localparam logic [OPENUM_W-1:0] OP_BGEU   = OPENUM_W'(10);
    localparam logic [OPENUM_W-1:0] OP_ADDI   = OPENUM_W'(19);
    localparam logic [OPENUM_W-1:0] OP_SLTI   = OPENUM_W'(20);
    localparam logic [OPENUM_W-1:0] OP_SLTIU  = OPENUM_W'(21);
    localparam logic [OPENUM_W-1:0] OP_XORI   = OPENUM_W'(22);
    localparam logic [OPENUM_W-1:0] OP_ORI    = OPENUM_W'(23);
    localparam logic [OPENUM_W-1:0] OP_ANDI   = OPENUM_W'(24);
    localparam logic [OPENUM_W-1:0] OP_SLLI   = OPENUM_W'(25);
    localparam logic [OPENUM_W-1:0] OP_SRLI   = OPENUM_W'(26);
    localparam logic [OPENUM_W-1:0] OP_SRAI   = OPENUM_W'(27);
    localparam logic [OPENUM_W-1:0] OP_ADD    = OPENUM_W'(28);
    localparam logic [OPENUM_W-1:0] OP_SUB    = OPENUM_W'(29);
    localparam logic [OPENUM_W-1:0] OP_SLL    = OPENUM_W'(30);
    localparam logic [OPENUM_W-1:0] OP_SLT    = OPENUM_W'(31);
    localparam logic [OPENUM_W-1:0] OP_SLTU   = OPENUM_W'(32);
    localparam logic [OPENUM_W-1:0] OP_XOR    = OPENUM_W'(33);
    localparam logic [OPENUM_W-1:0] OP_SRL    = OPENUM_W'(34);
    localparam logic [OPENUM_W-1:0] OP_SRA    = OPENUM_W'(35);
    localparam logic [OPENUM_W-1:0] OP_OR     = OPENUM_W'(36);
    localparam logic [OPENUM_W-1:0] OP_AND    = OPENUM_W'(37);
`ifdef ALU_MUL_EN
    localparam logic [OPENUM_W-1:0] OP_MUL    = OPENUM_W'(38);
    localparam logic [OPENUM_W-1:0] OP_MULH   = OPENUM_W'(39);
    localparam logic [OPENUM_W-1:0] OP_MULHSU = OPENUM_W'(40);
    localparam logic [OPENUM_W-1:0] OP_MULHU  = OPENUM_W'(41);
`endif

    logic [XLEN-1:0] val_c, npc_c, pc4_c, br_tgt_c;
    logic            jump_c;

    logic                 vld_p1;
    logic [ROB_POS_W-1:0] rob_p1;
    logic [XLEN-1:0]      val_p1, npc_p1;
    logic                 jump_p1;
    logic [XLEN-1:0]      s2_val;

`ifdef ALU_MUL_EN
    logic        mul_c, mul_hi_c, a_neg_c, b_neg_c;
    logic [31:0] pp0_c, pp1_c, pp2_c, pp3_c, corr_c;
    logic        mul_p1, mul_hi_p1;
    logic [31:0] pp0_p1, pp1_p1, pp2_p1, pp3_p1, corr_p1;
    logic [63:0] prod_c;
`endif

    assign pc4_c    = alu_pc + XLEN'(4);
    assign br_tgt_c = alu_pc + alu_imm;

    // Single-cycle result, branch decision and next PC for the dispatched op
    always_comb begin
        val_c  = '0;
        jump_c = 1'b0;
        npc_c  = pc4_c;
        case (alu_openum)
            OP_LUI:   val_c = alu_imm;
            OP_AUIPC: val_c = br_tgt_c;
            OP_JAL: begin
                val_c  = pc4_c;
                jump_c = 1'b1;
                npc_c  = br_tgt_c;
            end
            OP_JALR: begin
                val_c  = pc4_c;
                jump_c = 1'b1;
                npc_c  = (alu_rs1_val + alu_imm) & ~XLEN'(1);
            end
            OP_BEQ:   jump_c = (alu_rs1_val == alu_rs2_val);
            OP_BNE:   jump_c = (alu_rs1_val != alu_rs2_val);
            OP_BLT:   jump_c = ($signed(alu_rs1_val) <  $signed(alu_rs2_val));
            OP_BGE:   jump_c = ($signed(alu_rs1_val) >= $signed(alu_rs2_val));
            OP_BLTU:  jump_c = (alu_rs1_val <  alu_rs2_val);
            OP_BGEU:  jump_c = (alu_rs1_val >= alu_rs2_val);
            OP_ADDI:  val_c = alu_rs1_val + alu_imm;
            OP_SLTI:  val_c = XLEN'($signed(alu_rs1_val) < $signed(alu_imm));
            OP_SLTIU: val_c = XLEN'(alu_rs1_val < alu_imm);
            OP_XORI:  val_c = alu_rs1_val ^ alu_imm;
            OP_ORI:   val_c = alu_rs1_val | alu_imm;
            OP_ANDI:  val_c = alu_rs1_val & alu_imm;
            OP_SLLI:  val_c = alu_rs1_val << alu_imm[4:0];
            OP_SRLI:  val_c = alu_rs1_val >> alu_imm[4:0];
            OP_SRAI:  val_c = $signed(alu_rs1_val) >>> alu_imm[4:0];
            OP_ADD:   val_c = alu_rs1_val + alu_rs2_val;
            OP_SUB:   val_c = alu_rs1_val - alu_rs2_val;
            OP_SLL:   val_c = alu_rs1_val << alu_rs2_val[4:0];
            OP_SLT:   val_c = XLEN'($signed(alu_rs1_val) < $signed(alu_rs2_val));
            OP_SLTU:  val_c = XLEN'(alu_rs1_val < alu_rs2_val);
            OP_XOR:   val_c = alu_rs1_val ^ alu_rs2_val;
            OP_SRL:   val_c = alu_rs1_val >> alu_rs2_val[4:0];
            OP_SRA:   val_c = $signed(alu_rs1_val) >>> alu_rs2_val[4:0];
            OP_OR:    val_c = alu_rs1_val | alu_rs2_val;
            OP_AND:   val_c = alu_rs1_val & alu_rs2_val;
            default:  val_c = '0;
        endcase
        if (jump_c && (alu_openum >= OP_BEQ) && (alu_openum <= OP_BGEU))
            npc_c = br_tgt_c;
    end

`ifdef ALU_MUL_EN
    // Partial products; the signed forms are recovered by subtracting the
    // other operand from the high word when a signed operand is negative
    always_comb begin
        mul_c    = (alu_openum >= OP_MUL) && (alu_openum <= OP_MULHU);
        mul_hi_c = (alu_openum != OP_MUL);
        a_neg_c  = ((alu_openum == OP_MULH) || (alu_openum == OP_MULHSU)) && alu_rs1_val[31];
        b_neg_c  = (alu_openum == OP_MULH) && alu_rs2_val[31];
        pp0_c    = {16'b0, alu_rs1_val[15:0]}  * {16'b0, alu_rs2_val[15:0]};
        pp1_c    = {16'b0, alu_rs1_val[31:16]} * {16'b0, alu_rs2_val[15:0]};
        pp2_c    = {16'b0, alu_rs1_val[15:0]}  * {16'b0, alu_rs2_val[31:16]};
        pp3_c    = {16'b0, alu_rs1_val[31:16]} * {16'b0, alu_rs2_val[31:16]};
        corr_c   = (a_neg_c ? alu_rs2_val : 32'b0) + (b_neg_c ? alu_rs1_val : 32'b0);
    end

    // Sum the registered partial products into the 64-bit product
    always_comb begin
        prod_c = {32'b0, pp0_p1} + {16'b0, pp1_p1, 16'b0} + {16'b0, pp2_p1, 16'b0}
               + {pp3_p1, 32'b0} - {corr_p1, 32'b0};
        s2_val = mul_p1 ? (mul_hi_p1 ? prod_c[63:32] : prod_c[31:0]) : val_p1;
    end
`else
    assign s2_val = val_p1;
`endif

    // S1 valid: cleared on reset or flush, frozen while rdy is low
    always_ff @(posedge clk) begin
        if (rst || clr)
            vld_p1 <= 1'b0;
        else if (rdy)
            vld_p1 <= alu_enable;
    end

    // S1 data: qualified by vld_p1, so no reset needed
    always_ff @(posedge clk) begin
        if (rdy) begin
            rob_p1  <= alu_rob_pos;
            val_p1  <= val_c;
            npc_p1  <= npc_c;
            jump_p1 <= jump_c;
`ifdef ALU_MUL_EN
            mul_p1    <= mul_c;
            mul_hi_p1 <= mul_hi_c;
            pp0_p1    <= pp0_c;
            pp1_p1    <= pp1_c;
            pp2_p1    <= pp2_c;
            pp3_p1    <= pp3_c;
            corr_p1   <= corr_c;
`endif
        end
    end

    // S2: result bus register; data only moves when a valid result arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            result_ready   <= 1'b0;
            result_rob_pos <= '0;
            result_val     <= '0;
            result_jump    <= 1'b0;
            result_pc      <= '0;
        end else if (clr) begin
            result_ready <= 1'b0;
        end else if (rdy) begin
            result_ready <= vld_p1;
            if (vld_p1) begin
                result_rob_pos <= rob_p1;
                result_val     <= s2_val;
                result_jump    <= jump_p1;
                result_pc      <= npc_p1;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a scoreboard queue receives the
// expected result at dispatch and a negedge monitor pops it when the bus
// delivers (result_ready with rdy high). Honors ALU_MUL_EN.
module tb_alu_exec_unit;

    typedef struct packed {
        logic [4:0]  rob;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } res_t;

    localparam logic [5:0] LUI = 6'd1, AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4;
    localparam logic [5:0] BEQ = 6'd5, BNE = 6'd6, BLT = 6'd7, BGE = 6'd8;
    localparam logic [5:0] BLTU = 6'd9, BGEU = 6'd10;
    localparam logic [5:0] ADDI = 6'd19, SLTI = 6'd20, SLTIU = 6'd21, XORI = 6'd22;
    localparam logic [5:0] ORI = 6'd23, ANDI = 6'd24, SLLI = 6'd25, SRLI = 6'd26;
    localparam logic [5:0] SRAI = 6'd27, ADD = 6'd28, SUB = 6'd29, SLL = 6'd30;
    localparam logic [5:0] SLT = 6'd31, SLTU = 6'd32, XOR_ = 6'd33, SRL = 6'd34;
    localparam logic [5:0] SRA = 6'd35, OR_ = 6'd36, AND_ = 6'd37;
    localparam logic [5:0] MUL = 6'd38, MULH = 6'd39, MULHSU = 6'd40, MULHU = 6'd41;

    logic        clk = 1'b0;
    logic        rst, rdy, clr, alu_enable;
    logic [5:0]  alu_openum;
    logic [4:0]  alu_rob_pos;
    logic [31:0] alu_rs1_val, alu_rs2_val, alu_imm, alu_pc;
    logic        result_ready, result_jump;
    logic [4:0]  result_rob_pos;
    logic [31:0] result_val, result_pc;

    int   vectors = 0;
    int   miscompares = 0;
    res_t sb[$];
    logic [31:0] last_val = 32'h0;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .alu_enable(alu_enable), .alu_openum(alu_openum), .alu_rob_pos(alu_rob_pos),
        .alu_rs1_val(alu_rs1_val), .alu_rs2_val(alu_rs2_val), .alu_imm(alu_imm),
        .alu_pc(alu_pc), .result_ready(result_ready), .result_rob_pos(result_rob_pos),
        .result_val(result_val), .result_jump(result_jump), .result_pc(result_pc)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_model(input logic [5:0] op, input logic [4:0] tag,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] imm, input logic [31:0] pc);
        res_t r;
        longint p;
        logic cond;
        r.rob = tag; r.val = 32'h0; r.jump = 1'b0; r.pc = pc + 32'd4;
        cond = 1'b0;
        p = 0;
        case (op)
            LUI:    r.val = imm;
            AUIPC:  r.val = pc + imm;
            JAL:    begin r.val = pc + 32'd4; r.jump = 1'b1; r.pc = pc + imm; end
            JALR:   begin r.val = pc + 32'd4; r.jump = 1'b1; r.pc = (a + imm) & 32'hFFFF_FFFE; end
            BEQ:    cond = (a == b);
            BNE:    cond = (a != b);
            BLT:    cond = ($signed(a) < $signed(b));
            BGE:    cond = ($signed(a) >= $signed(b));
            BLTU:   cond = (a < b);
            BGEU:   cond = (a >= b);
            ADDI:   r.val = a + imm;
            SLTI:   r.val = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            SLTIU:  r.val = (a < imm) ? 32'd1 : 32'd0;
            XORI:   r.val = a ^ imm;
            ORI:    r.val = a | imm;
            ANDI:   r.val = a & imm;
            SLLI:   r.val = a << imm[4:0];
            SRLI:   r.val = a >> imm[4:0];
            SRAI:   r.val = $signed(a) >>> imm[4:0];
            ADD:    r.val = a + b;
            SUB:    r.val = a - b;
            SLL:    r.val = a << b[4:0];
            SLT:    r.val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU:   r.val = (a < b) ? 32'd1 : 32'd0;
            XOR_:   r.val = a ^ b;
            SRL:    r.val = a >> b[4:0];
            SRA:    r.val = $signed(a) >>> b[4:0];
            OR_:    r.val = a | b;
            AND_:   r.val = a & b;
`ifdef ALU_MUL_EN
            MUL:    begin p = longint'(a) * longint'(b); r.val = p[31:0]; end
            MULH:   begin p = longint'($signed(a)) * longint'($signed(b)); r.val = p[63:32]; end
            MULHSU: begin p = longint'($signed(a)) * longint'(b); r.val = p[63:32]; end
            MULHU:  begin p = longint'(a) * longint'(b); r.val = p[63:32]; end
`endif
            default: r.val = 32'h0;
        endcase
        if (op >= BEQ && op <= BGEU) begin
            r.jump = cond;
            r.pc   = cond ? pc + imm : pc + 32'd4;
        end
        return r;
    endfunction

    // Scoreboard monitor: one delivery per cycle where result_ready and rdy are high
    always @(negedge clk) begin
        res_t got, exp;
        if (!rst && rdy && result_ready) begin
            got = '{result_rob_pos, result_val, result_jump, result_pc};
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result: got tag=%0d val=%h jump=%b pc=%h, required no result",
                         got.rob, got.val, got.jump, got.pc);
            end else begin
                exp = sb.pop_front();
                last_val = exp.val;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL result: got tag=%0d val=%h jump=%b pc=%h, required tag=%0d val=%h jump=%b pc=%h",
                             got.rob, got.val, got.jump, got.pc, exp.rob, exp.val, exp.jump, exp.pc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dispatch one op for one cycle; exp is pushed only when expected on the bus
    task automatic dispatch_exp(input logic [5:0] op, input logic [4:0] tag, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                                input res_t exp, input bit push);
        alu_enable = 1'b1; alu_openum = op; alu_rob_pos = tag;
        alu_rs1_val = a; alu_rs2_val = b; alu_imm = imm; alu_pc = pc;
        if (push) sb.push_back(exp);
        tick();
        alu_enable = 1'b0;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [4:0] tag, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc);
        dispatch_exp(op, tag, a, b, imm, pc, ref_model(op, tag, a, b, imm, pc), 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; clr = 1'b0;
        alu_enable = 1'b1; alu_openum = ADD; alu_rob_pos = 5'd9;
        alu_rs1_val = 32'h1234; alu_rs2_val = 32'h1; alu_imm = 32'h0; alu_pc = 32'h0;
        idle(3);
        vectors++;
        if ({result_ready, result_rob_pos, result_val, result_jump, result_pc} !== 71'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ready=%b tag=%0d val=%h jump=%b pc=%h, required all zero",
                     result_ready, result_rob_pos, result_val, result_jump, result_pc);
        end
        alu_enable = 1'b0;
        rdy = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (result_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b, required 0", result_ready);
        end
    endtask

    task automatic test_add_latency();
        res_t e;
        e = '{5'd3, 32'h8000_0000, 1'b0, 32'h0000_0204};
        dispatch_exp(ADD, 5'd3, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h200, e, 1'b1);
        vectors++;
        if (result_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL add_early: got ready=%b after first edge, required 0", result_ready);
        end
        tick();
        vectors++;
        if ({result_ready, result_rob_pos, result_val, result_jump, result_pc} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL add_result: got ready=%b tag=%0d val=%h jump=%b pc=%h, required ready=1 tag=3 val=80000000 jump=0 pc=00000204",
                     result_ready, result_rob_pos, result_val, result_jump, result_pc);
        end
        tick();
        vectors++;
        if (result_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL add_single_pulse: got ready=%b, required 0", result_ready);
        end
    endtask

    task automatic test_back_to_back();
        dispatch_exp(SRA, 5'd1, 32'h8000_0000, 32'd4, 32'h0, 32'h10, '{5'd1, 32'hF800_0000, 1'b0, 32'h14}, 1'b1);
        dispatch_exp(SLTU, 5'd2, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h14, '{5'd2, 32'd1, 1'b0, 32'h18}, 1'b1);
        vectors++;
        if ({result_ready, result_rob_pos, result_val} !== {1'b1, 5'd1, 32'hF800_0000}) begin
            miscompares++;
            $display("FAIL b2b_first: got ready=%b tag=%0d val=%h, required ready=1 tag=1 val=f8000000",
                     result_ready, result_rob_pos, result_val);
        end
        tick();
        vectors++;
        if ({result_ready, result_rob_pos, result_val} !== {1'b1, 5'd2, 32'd1}) begin
            miscompares++;
            $display("FAIL b2b_second: got ready=%b tag=%0d val=%h, required ready=1 tag=2 val=00000001",
                     result_ready, result_rob_pos, result_val);
        end
        idle(2);
    endtask

    task automatic test_control();
        dispatch_exp(BLT,  5'd10, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF8, 32'h100, '{5'd10, 32'h0, 1'b1, 32'hF8}, 1'b1);
        dispatch_exp(BGEU, 5'd11, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF8, 32'h100, '{5'd11, 32'h0, 1'b1, 32'hF8}, 1'b1);
        dispatch_exp(BEQ,  5'd12, 32'd1, 32'd2, 32'hFFFF_FFF8, 32'h100, '{5'd12, 32'h0, 1'b0, 32'h104}, 1'b1);
        dispatch_exp(JALR, 5'd13, 32'h1003, 32'h0, 32'd2, 32'h40, '{5'd13, 32'h44, 1'b1, 32'h1004}, 1'b1);
        dispatch_exp(JAL,  5'd14, 32'h0, 32'h0, 32'h20, 32'h40, '{5'd14, 32'h44, 1'b1, 32'h60}, 1'b1);
        dispatch_exp(LUI,  5'd15, 32'h0, 32'h0, 32'hABCD_E000, 32'h40, '{5'd15, 32'hABCD_E000, 1'b0, 32'h44}, 1'b1);
        dispatch_exp(AUIPC, 5'd16, 32'h0, 32'h0, 32'h1000, 32'h40, '{5'd16, 32'h1040, 1'b0, 32'h44}, 1'b1);
        dispatch_exp(6'd63, 5'd17, 32'h5, 32'h6, 32'h7, 32'h80, '{5'd17, 32'h0, 1'b0, 32'h84}, 1'b1);
        idle(3);
    endtask

    task automatic test_flush();
        dispatch_exp(ADD, 5'd5, 32'd1, 32'd1, 32'h0, 32'h0, '0, 1'b0);
        clr = 1'b1;
        dispatch_exp(ADD, 5'd6, 32'd2, 32'd2, 32'h0, 32'h0, '0, 1'b0);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (result_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_drop: got ready=%b tag=%0d at cycle %0d, required 0",
                         result_ready, result_rob_pos, i);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        dispatch(XORI, 5'd7, 32'h0F0F_0F0F, 32'h0, 32'hFFFF_FFFF, 32'h300);
        rdy = 1'b0;
        alu_enable = 1'b1; alu_rob_pos = 5'd9; alu_openum = ADD;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({result_ready, result_val} !== {1'b0, last_val}) begin
                miscompares++;
                $display("FAIL stall_frozen: got ready=%b val=%h, required ready=0 val=%h",
                         result_ready, result_val, last_val);
            end
        end
        alu_enable = 1'b0;
        rdy = 1'b1;
        tick();
        vectors++;
        if ({result_ready, result_rob_pos} !== {1'b1, 5'd7}) begin
            miscompares++;
            $display("FAIL stall_release: got ready=%b tag=%0d, required ready=1 tag=7", result_ready, result_rob_pos);
        end
        tick();
        vectors++;
        if (result_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_no_dup: got ready=%b, required 0", result_ready);
        end
        // Held valid: result visible, then frozen with rdy low
        dispatch(SUB, 5'd8, 32'd10, 32'd3, 32'h0, 32'h400);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({result_ready, result_rob_pos, result_val} !== {1'b1, 5'd8, 32'd7}) begin
                miscompares++;
                $display("FAIL stall_hold: got ready=%b tag=%0d val=%h, required ready=1 tag=8 val=00000007",
                         result_ready, result_rob_pos, result_val);
            end
        end
        rdy = 1'b1;
        tick();
        vectors++;
        if (result_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold_release: got ready=%b, required 0", result_ready);
        end
    endtask

    task automatic test_mul();
`ifdef ALU_MUL_EN
        dispatch_exp(MULH,   5'd20, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, '{5'd20, 32'h4000_0000, 1'b0, 32'h4}, 1'b1);
        dispatch_exp(MULHSU, 5'd21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, '{5'd21, 32'hFFFF_FFFF, 1'b0, 32'h4}, 1'b1);
        dispatch_exp(MUL,    5'd22, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, '{5'd22, 32'h0, 1'b0, 32'h4}, 1'b1);
        dispatch_exp(MULHU,  5'd23, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, '{5'd23, 32'hFFFF_FFFE, 1'b0, 32'h4}, 1'b1);
        dispatch_exp(MUL,    5'd24, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, '{5'd24, 32'h242D_2080, 1'b0, 32'h4}, 1'b1);
`else
        dispatch_exp(MUL,    5'd22, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, '{5'd22, 32'h0, 1'b0, 32'h4}, 1'b1);
        dispatch_exp(MULHU,  5'd23, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, '{5'd23, 32'h0, 1'b0, 32'h4}, 1'b1);
`endif
        idle(3);
    endtask

    task automatic test_random();
        logic [5:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(42, 63)) : 6'($urandom_range(0, 41));
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            rdy = ($urandom_range(0, 4) != 0);
            alu_enable = ($urandom_range(0, 5) != 0);
            alu_openum = op; alu_rob_pos = 5'($urandom_range(1, 31));
            alu_rs1_val = a; alu_rs2_val = b; alu_imm = $urandom(); alu_pc = {$urandom_range(0, 32'hFFFF), 2'b00};
            if (rdy && alu_enable)
                sb.push_back(ref_model(op, alu_rob_pos, a, b, alu_imm, alu_pc));
            tick();
        end
        alu_enable = 1'b0;
        rdy = 1'b1;
        idle(4);
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_control();
        test_flush();
        test_stall();
        test_mul();
        test_random();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Integer execution unit on the consumer side of the reservation-station dispatch interface.
- Accepts at most one ready instruction per cycle (operands resolved, ROB tag attached) and computes it in a fixed 2-stage pipeline.
- Broadcasts the result on the common result bus consumed by the RS, LSB and ROB: value, ROB tag, branch/jump decision and next PC.
- Has no backpressure; it must accept one operation every cycle.

Parameters:
- ROB_POS_W, 5, width of the wrapped ROB position tag; tag 0 is reserved for "no dependency" and is never issued.
- OPENUM_W, 6, width of the internal opcode enumeration (shared `OPENUM_* encodings from definition.v).
- XLEN, 32, data and address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- clr  in  1  pipeline flush on misprediction, synchronous
- alu_enable  in  1  dispatch valid from RS
- alu_openum  in  OPENUM_W  operation
- alu_rob_pos  in  ROB_POS_W  destination ROB tag
- alu_rs1_val  in  XLEN  operand 1
- alu_rs2_val  in  XLEN  operand 2
- alu_imm  in  XLEN  sign-extended immediate
- alu_pc  in  XLEN  instruction PC
- result_ready  out  1  result bus valid
- result_rob_pos  out  ROB_POS_W  tag of the result
- result_val  out  XLEN  rd writeback value
- result_jump  out  1  control transfer taken
- result_pc  out  XLEN  resolved next PC

Behaviour:
- Pipeline: S1 register (computed value, next PC, jump, tag, valid) -> S2 output register driving the result_* outputs.
- Latency:
  - Dispatch sampled at clock edge E is in S1 after E.
  - result_ready=1 is visible after edge E+1, for exactly one cycle per dispatch.
  - Throughput is 1 per cycle; back-to-back dispatches produce back-to-back results in issue order.
- Reset (rst) or clr: both valid bits cleared and result_ready=0 on the next cycle. result_rob_pos, result_val, result_pc are driven to 0 and result_jump to 0 on reset. clr with alu_enable in the same cycle drops the dispatch. rst/clr take priority over rdy.
- rdy=0: no register updates. Outputs hold their values, including a held result_ready=1; consumers gate on rdy. A dispatch arriving while rdy=0 is ignored (RS also freezes).
- Arithmetic, all modulo 2^32:
  - Shifts use the low 5 bits of rs2 (R-type) or imm (I-type).
  - SRA and SRAI are arithmetic shifts.
  - SLT and SLTI are signed comparisons; SLTU and SLTIU are unsigned.
- LUI: val=imm. AUIPC: val=pc+imm. Both: jump=0, next pc=pc+4.
- JAL: val=pc+4, jump=1, next pc=pc+imm.
- JALR: val=pc+4, jump=1, next pc=(rs1+imm) & ~1.
- BEQ/BNE/BLT/BGE/BLTU/BGEU: val=0, jump=condition, next pc = jump ? pc+imm : pc+4.
- All other ALU ops: jump=0, next pc=pc+4.
- Unknown or unsupported opcode: still produces a result with val=0, jump=0, next pc=pc+4. A dispatched tag is never lost.
- Tag is passed through unchanged. The unit does not check for duplicate tags.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - Supports MUL, MULH, MULHSU, MULHU.
  - S1 registers four 16x16 unsigned partial products plus sign-correction terms. S2 sums them to the 64-bit product and selects the low or high word.
  - Latency stays 2, so results never collide with single-cycle ops.
- Undefined: these opcodes take the unknown-opcode path (val=0). No multiplier logic is synthesized.

Test Plan:
- ADD rs1=0x7FFFFFFF, rs2=1, tag=3 at edge E -> after E+1: result_ready=1, result_rob_pos=3, result_val=0x80000000, jump=0, pc=alu_pc+4; result_ready=0 after E+2 with no further dispatch.
- Back-to-back: SRA rs1=0x80000000, rs2=4 (tag 1), then SLTU rs1=1, rs2=0xFFFFFFFF (tag 2) -> consecutive results 0xF8000000 (tag 1) then 1 (tag 2).
- Control transfers:
  - BLT rs1=-1, rs2=0, pc=0x100, imm=-8 -> jump=1, pc=0xF8.
  - BGEU rs1=-1, rs2=0, pc=0x100, imm=-8 -> jump=1, pc=0xF8.
  - BEQ rs1=1, rs2=2 at pc=0x100 -> jump=0, pc=0x104.
  - JALR rs1=0x1003, imm=2, pc=0x40 -> val=0x44, pc=0x1004.
- Flush: dispatch tag 5, assert clr the next cycle together with a dispatch of tag 6 -> no result_ready for tag 5 or tag 6.
- Stall: dispatch tag 7, then rdy=0 for 3 cycles -> result_* frozen; tag 7 result appears exactly once after rdy returns, with no duplication.
- ALU_MUL_EN:
  - MULH 0x80000000 * 0x80000000 -> 0x40000000.
  - MULHSU -1 * 0xFFFFFFFF -> 0xFFFFFFFF.
  - MUL 0x10000 * 0x10000 -> 0.
  - Without the macro, MUL -> val=0 and result_ready still asserted.
